mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx_pkg.sv | 28 ++
 rtl/mmio_uart_tx_if.sv | 23 ++
 rtl/mmio_uart_tx_fifo.sv | 86 ++++++++
 rtl/mmio_uart_tx.sv | 155 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serial FSM state type.
package mmio_uart_tx_pkg;

  localparam int unsigned XLEN_WIDTH = 32;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVERRUN = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Word offset inside the 16-byte window; byte-lane bits are ignored.
  function automatic logic [3:0] word_off(input logic [XLEN_WIDTH-1:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-side load/store port as seen by the UART window: the mem stage is the
// master, the UART the slave.
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  logic [XLEN_WIDTH-1:0] read_addr;
  logic [XLEN_WIDTH-1:0] read_data;
  logic                  write_en;
  logic [XLEN_WIDTH-1:0] write_addr;
  logic [XLEN_WIDTH-1:0] write_data;
  logic                  hit;

  modport master (
    output read_addr, write_en, write_addr, write_data,
    input  read_data, hit
  );

  modport slave (
    input  read_addr, write_en, write_addr, write_data,
    output read_data, hit
  );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte queue feeding the UART shifter. MMIO_UART_TX_FIFO_EN selects a 4-entry
// FIFO; otherwise a single holding register is used.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic push_ok;
  logic pop_ok;

  // Fullness is judged on the pre-edge state, so a push into a full queue is
  // lost even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

`ifdef MMIO_UART_TX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] count_q, count_d;

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign dout  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
    if (push_ok) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 2'd1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`else
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  assign full  = valid_q;
  assign empty = !valid_q;
  assign dout  = data_q;

  always_comb begin
    valid_d = (valid_q && !pop_ok) || push_ok;
    data_d  = push_ok ? din : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV register window and
// serial FSM. Queue depth follows MMIO_UART_TX_FIFO_EN (see uart_tx_fifo).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [XLEN_WIDTH-1:0] BASE    = 32'h1000_0000,
  parameter logic [15:0]           CLK_DIV = 16'd868
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx
);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic        overrun_q, overrun_d;

  logic        rd_in_win, wr_in_win;
  logic        wr_txdata, wr_status, wr_div;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [3:0]  status;
  logic        bit_done;
  logic        unused_wdata;

  assign unused_wdata = ^bus.write_data[XLEN_WIDTH-1:16];

  assign rd_in_win = (bus.read_addr[XLEN_WIDTH-1:4]  == BASE[XLEN_WIDTH-1:4]);
  assign wr_in_win = (bus.write_addr[XLEN_WIDTH-1:4] == BASE[XLEN_WIDTH-1:4]);
  assign bus.hit   = rd_in_win || (bus.write_en && wr_in_win);

  assign wr_txdata = bus.write_en && wr_in_win && (word_off(bus.write_addr) == UART_TXDATA);
  assign wr_status = bus.write_en && wr_in_win && (word_off(bus.write_addr) == UART_STATUS);
  assign wr_div    = bus.write_en && wr_in_win && (word_off(bus.write_addr) == UART_DIV);

  uart_tx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (bus.write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = (state_q != ST_IDLE) || !fifo_empty;
    status[STAT_FULL]    = fifo_full;
    status[STAT_EMPTY]   = fifo_empty;
    status[STAT_OVERRUN] = overrun_q;
  end

  always_comb begin
    bus.read_data = '0;
    if (rd_in_win) begin
      case (word_off(bus.read_addr))
        UART_STATUS: bus.read_data = {{(XLEN_WIDTH-4){1'b0}}, status};
        UART_DIV:    bus.read_data = {{(XLEN_WIDTH-16){1'b0}}, div_q};
        default:     bus.read_data = '0;
      endcase
    end
  end

  // Overrun set takes priority over a same-edge STATUS write clearing it.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_status) overrun_d = 1'b0;
    if (wr_txdata && fifo_full) overrun_d = 1'b1;
    div_d = div_q;
    if (wr_div) div_d = (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
  end

  // Bit period ends when the down counter reaches 1; reload picks up any new
  // DIV value only here, so a mid-bit DIV write never stretches the current bit.
  assign bit_done = (cnt_q <= 16'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = div_q;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_done) begin
          cnt_d     = div_q;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[bit_idx_q];
        if (bit_done) begin
          cnt_d = div_q;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = div_q;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_q     <= CLK_DIV;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed steps plus randomized traffic
// compared cycle by cycle against a frame-timeline reference model.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef MMIO_UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE(BASE), .CLK_DIV(16'd868)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  // Each accepted byte becomes a frame occupying [start, start + 10*d) cycles.
  typedef struct {
    int         start;
    int         d;
    logic [7:0] b;
  } frame_t;

  frame_t frames[$];
  int     cyc      = 0;
  int     mdiv     = 868;
  logic   m_ovr    = 1'b0;
  int     pass_cnt = 0;
  int     total    = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic logic m_tx(input int c);
    int bitn;
    foreach (frames[i]) begin
      if (c >= frames[i].start && c < frames[i].start + 10 * frames[i].d) begin
        bitn = (c - frames[i].start) / frames[i].d;
        if (bitn == 0) return 1'b0;
        if (bitn == 9) return 1'b1;
        return frames[i].b[bitn-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit m_busy(input int c);
    foreach (frames[i]) if (frames[i].start + 10 * frames[i].d > c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_status(input int c);
    int waiting;
    waiting = 0;
    foreach (frames[i]) if (frames[i].start > c) waiting++;
    return {28'd0, m_ovr, (waiting == 0), (waiting == DEPTH), m_busy(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: capture the bus as the DUT sees it, advance the model, settle.
  task automatic step();
    logic        we, r;
    logic [31:0] wa, wd;
    int          waiting, last_end, st;
    frame_t      f;
    we = bus.write_en; wa = bus.write_addr; wd = bus.write_data; r = rst;
    @(posedge clk);
    cyc++;
    if (r) begin
      frames.delete();
      m_ovr = 1'b0;
      mdiv  = 868;
    end else if (we && in_win(wa)) begin
      case (wa[3:2])
        2'd0: begin
          waiting = 0;
          foreach (frames[i]) if (frames[i].start >= cyc) waiting++;
          if (waiting < DEPTH) begin
            last_end = (frames.size() > 0) ? frames[$].start + 10 * frames[$].d : 0;
            st       = (cyc + 1 > last_end) ? cyc + 1 : last_end;
            f.start  = st;
            f.d      = mdiv;
            f.b      = wd[7:0];
            frames.push_back(f);
          end else begin
            m_ovr = 1'b1;
          end
        end
        2'd1: m_ovr = 1'b0;
        2'd2: mdiv = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic chk_cycle();
    chk("tx_line", {31'd0, tx}, {31'd0, m_tx(cyc)});
    chk("status", bus.read_data, m_status(cyc));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.write_en   = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
    step();
    bus.write_en   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr(a, d);
    chk_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      chk_cycle();
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_busy(cyc) && guard < 20000) begin
      step();
      chk_cycle();
      guard++;
    end
    run(2);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.read_addr = a;
    #1;
    v = bus.read_data;
    bus.read_addr = BASE + 32'h4;
    #1;
  endtask

  initial begin
    logic [31:0] v;
    int          s, dv, n;

    bus.read_addr  = BASE + 32'h4;
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_status", bus.read_data, 32'h4);
    rd(BASE + 32'h8, v);
    chk("rst_div", v, 32'd868);
    chk_cycle();

    // Single 0x55 frame at DIV=4
    store(BASE + 32'h8, 32'd4);
    store(BASE, 32'h55);
    drain();

    // Two frames back to back at DIV=2
    store(BASE + 32'h8, 32'd2);
    store(BASE, 32'hA3);
    run(1);
    store(BASE, 32'h0F);
    drain();

    // Burst of six stores during the first start bit at DIV=8
    store(BASE + 32'h8, 32'd8);
    for (int i = 0; i < 6; i++) store(BASE, 32'($urandom));
    rd(BASE + 32'h4, v);
    chk("burst_status", v, m_status(cyc));
`ifdef MMIO_UART_TX_FIFO_EN
    chk("burst_status_fifo", v, 32'hB);
`endif
    run(3);
    store(BASE + 32'h4, 32'h0);
    drain();

    // DIV=0 stored as 1; offsets 0x0/0xC read 0; writes to 0xC ignored
    store(BASE + 32'h8, 32'd0);
    rd(BASE + 32'h8, v);
    chk("div_zero", v, 32'd1);
    rd(BASE, v);
    chk("txdata_read", v, 32'd0);
    store(BASE + 32'hC, 32'hFF);
    rd(BASE + 32'hC, v);
    chk("off_c_read", v, 32'd0);
    run(4);

    // Window decode and hit
    bus.read_addr = 32'h0FFF_FFFC;
    #1;
    chk("hit_below", {31'd0, bus.hit}, 32'd0);
    chk("rdata_below", bus.read_data, 32'd0);
    bus.read_addr = 32'h1000_0010;
    #1;
    chk("rdata_above", bus.read_data, 32'd0);
    bus.read_addr = BASE + 32'hC;
    #1;
    chk("hit_in_win", {31'd0, bus.hit}, 32'd1);
    bus.read_addr  = 32'h0FFF_FFFC;
    bus.write_en   = 1'b1;
    bus.write_addr = BASE + 32'h4;
    #1;
    chk("hit_write", {31'd0, bus.hit}, 32'd1);
    bus.write_en   = 1'b0;
    bus.read_addr  = BASE + 32'h4;
    #1;

    // Stores outside the window produce no frame
    store(32'h1000_0010, 32'h12);
    store(32'h0FFF_FFF0, 32'h34);
    run(12);

    // DIV 3 -> 6 written during data bit 0
    store(BASE + 32'h8, 32'd3);
    wr(BASE, 32'hAA);
    s = cyc + 1;
    while (cyc < s + 3) step();
    wr(BASE + 32'h8, 32'd6);
    chk("divchg_b0", {31'd0, tx}, 32'd0);
    while (cyc < s + 25) begin
      step();
      if (cyc == s + 5)  chk("divchg_b0_end", {31'd0, tx}, 32'd0);
      if (cyc == s + 6)  chk("divchg_b1_start", {31'd0, tx}, 32'd1);
      if (cyc == s + 11) chk("divchg_b1_end", {31'd0, tx}, 32'd1);
      if (cyc == s + 12) chk("divchg_b2_start", {31'd0, tx}, 32'd0);
      if (cyc == s + 17) chk("divchg_b2_end", {31'd0, tx}, 32'd0);
      if (cyc == s + 18) chk("divchg_b3_start", {31'd0, tx}, 32'd1);
      if (cyc == s + 23) chk("divchg_b3_end", {31'd0, tx}, 32'd1);
      if (cyc == s + 24) chk("divchg_b4_start", {31'd0, tx}, 32'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cycle();

    // Reset during data bit 4, with a second byte waiting
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h00);
    s = cyc + 1;
    step();
    wr(BASE, 32'h7E);
    while (cyc < s + 21) step();
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_status", bus.read_data, 32'h4);
    rd(BASE + 32'h8, v);
    chk("mid_rst_div", v, 32'd868);
    run(60);

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      dv = int'($urandom_range(1, 4));
      store(BASE + 32'h8, 32'(dv));
      n = int'($urandom_range(2, 7));
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 4) == 0) store(BASE + 32'h4, 32'($urandom));
        else store(BASE, 32'($urandom));
        run(int'($urandom_range(0, 10)));
      end
      drain();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
